// File: rtl/pipeline_types.sv
// Shared pipeline types: register-file write port and writeback request records.
package pipeline_types;

  localparam int unsigned WB_NUM_SRC = 3;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_req_t;

  typedef struct packed {
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
  } data_write_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-source writeback request queue; pointers carry an extra wrap bit for full/empty.
// REGFILE_WB_PENDING_QUERY_EN adds an address-match port over the valid entries.
module wb_fifo
  import pipeline_types::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    flush,
  input  logic    push_valid,
  output logic    push_ready,
  input  wb_req_t push_req,
  input  logic    pop,
  output wb_req_t head,
  output logic    empty
`ifdef REGFILE_WB_PENDING_QUERY_EN
  ,
  input  logic [4:0] query_addr,
  output logic       query_hit
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  wb_req_t     mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // rst gates ready so the source sees no acceptance while reset is held
  assign push_ready = !full && !flush && rst;
  assign push       = push_valid && push_ready;
  assign head       = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= push_req;
  end

`ifdef REGFILE_WB_PENDING_QUERY_EN
  logic [AW:0] count;
  assign count = wr_ptr - rd_ptr;

  // slot i is live when its distance from the read pointer is below the fill count
  always_comb begin
    query_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (({1'b0, AW'(i) - rd_ptr[AW-1:0]} < count) &&
          (mem[i].addr == query_addr) && (query_addr != 5'd0))
        query_hit = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter: NUM_SRC request queues feeding one registered regfile write port.
// REGFILE_WB_PENDING_QUERY_EN adds pend_query_addr/pend_hit for pending-write lookups.
module regfile_wb_arbiter
  import pipeline_types::*;
#(
  parameter int unsigned NUM_SRC    = WB_NUM_SRC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [NUM_SRC-1:0]     src_valid,
  output logic [NUM_SRC-1:0]     src_ready,
  input  wb_req_t [NUM_SRC-1:0]  src_req,
  output data_write_t            data_write,
  output logic                   busy
`ifdef REGFILE_WB_PENDING_QUERY_EN
  ,
  input  logic [4:0]             pend_query_addr,
  output logic                   pend_hit
`endif
);

  localparam int unsigned PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] pop;
  wb_req_t            head [NUM_SRC];
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      grant_idx;
  logic               grant_vld;

`ifdef REGFILE_WB_PENDING_QUERY_EN
  logic [NUM_SRC-1:0] fifo_hit;
`endif

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    wb_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .push_valid (src_valid[g]),
      .push_ready (src_ready[g]),
      .push_req   (src_req[g]),
      .pop        (pop[g]),
      .head       (head[g]),
      .empty      (empty[g])
`ifdef REGFILE_WB_PENDING_QUERY_EN
      ,
      .query_addr (pend_query_addr),
      .query_hit  (fifo_hit[g])
`endif
    );
  end

  // rr_ptr holds the first index to consider, i.e. one past the last grant
  always_comb begin
    int unsigned idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int unsigned off = 0; off < NUM_SRC; off++) begin
      idx = 32'(rr_ptr) + off;
      if (idx >= NUM_SRC)
        idx = idx - NUM_SRC;
      if (!grant_vld && !empty[PW'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(idx);
      end
    end
    if (flush)
      grant_vld = 1'b0;
  end

  always_comb begin
    pop = '0;
    if (grant_vld)
      pop[grant_idx] = 1'b1;
  end

  // Address-0 entries are consumed and advance the pointer but never enable the write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_write <= '0;
      rr_ptr     <= '0;
    end else if (grant_vld) begin
      data_write.write_en   <= (head[grant_idx].addr != 5'd0);
      data_write.write_addr <= head[grant_idx].addr;
      data_write.write_data <= head[grant_idx].data;
      rr_ptr                <= (grant_idx == PW'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
    end else begin
      data_write.write_en <= 1'b0;
    end
  end

  assign busy = ~&empty | data_write.write_en;

`ifdef REGFILE_WB_PENDING_QUERY_EN
  assign pend_hit = (|fifo_hit) ||
                    (data_write.write_en && (data_write.write_addr == pend_query_addr) &&
                     (pend_query_addr != 5'd0));
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter; data[29:28] of each request tags its scoreboard queue.
// Pending-query checks run only when REGFILE_WB_PENDING_QUERY_EN is defined.
module tb_regfile_wb_arbiter;
  import pipeline_types::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [2:0]      src_valid;
  logic [2:0]      src_ready;
  wb_req_t [2:0]   src_req;
  data_write_t     data_write;
  logic            busy;
`ifdef REGFILE_WB_PENDING_QUERY_EN
  logic [4:0]      pend_query_addr;
  logic            pend_hit;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  wb_req_t     sb [4][$];
  logic [2:0]  xfer;

  regfile_wb_arbiter #(
    .NUM_SRC    (3),
    .FIFO_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_req    (src_req),
    .data_write (data_write),
    .busy       (busy)
`ifdef REGFILE_WB_PENDING_QUERY_EN
    ,
    .pend_query_addr (pend_query_addr),
    .pend_hit        (pend_hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic wb_req_t mk(input logic [4:0] a, input logic [1:0] tag, input logic [27:0] d);
    wb_req_t r;
    r.addr = a;
    r.data = {2'b00, tag, d};
    return r;
  endfunction

  function automatic int unsigned sb_count();
    int unsigned n = 0;
    for (int i = 0; i < 4; i++) n += sb[i].size();
    return n;
  endfunction

  task automatic sb_clear();
    for (int i = 0; i < 4; i++) sb[i].delete();
  endtask

  // Record handshakes just before the edge, then move to 1 time unit after it.
  task automatic step();
    @(negedge clk);
    xfer = src_valid & src_ready;
    for (int i = 0; i < 3; i++)
      if (xfer[i] && src_req[i].addr != 5'd0)
        sb[src_req[i].data[29:28]].push_back(src_req[i]);
    @(posedge clk);
    #1;
  endtask

  task automatic burst3(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [27:0] d);
    src_req[0] = mk(a0, 2'd0, d);
    src_req[1] = mk(a1, 2'd1, d);
    src_req[2] = mk(a2, 2'd2, d);
    src_valid  = 3'b111;
  endtask

  always @(negedge clk) begin
    if (data_write.write_en) begin
      logic [1:0] t;
      wb_req_t    e;
      t = data_write.write_data[29:28];
      if (sb[t].size() == 0) begin
        check("unexpected_write", {data_write.write_addr, data_write.write_data}, 64'd0);
      end else begin
        e = sb[t].pop_front();
        check("wb_order", {data_write.write_addr, data_write.write_data}, {e.addr, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_r0;
    logic [3:0] exp_r1;
    int         n0;
    int         n1;
    logic [4:0] a0 [3];
    logic [4:0] a1 [3];

    rst       = 1'b1;
    flush     = 1'b0;
    src_valid = 3'b000;
    src_req   = '0;
`ifdef REGFILE_WB_PENDING_QUERY_EN
    pend_query_addr = 5'd0;
`endif
    #1 rst = 1'b0;
    #2;
    check("rst_ready", src_ready, 3'b000);
    check("rst_dw", data_write, 64'd0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // contention: three sources at once, then a second burst
    burst3(5'd1, 5'd2, 5'd3, 28'h0000100);
    check("cont_ready", src_ready, 3'b111);
    step();
    src_valid = 3'b000;
    check("cont_busy", busy, 1'b1);
    check("cont_en0", data_write.write_en, 1'b0);
    step(); check("cont_a1", {data_write.write_en, data_write.write_addr}, {1'b1, 5'd1});
    step(); check("cont_a2", {data_write.write_en, data_write.write_addr}, {1'b1, 5'd2});
    step(); check("cont_a3", {data_write.write_en, data_write.write_addr}, {1'b1, 5'd3});
    burst3(5'd4, 5'd5, 5'd6, 28'h0000200);
    step();
    src_valid = 3'b000;
    step(); check("cont_a4", {data_write.write_en, data_write.write_addr}, {1'b1, 5'd4});
    step(); check("cont_a5", {data_write.write_en, data_write.write_addr}, {1'b1, 5'd5});
    step(); check("cont_a6", {data_write.write_en, data_write.write_addr}, {1'b1, 5'd6});
    step();
    check("cont_idle_en", data_write.write_en, 1'b0);
    check("cont_idle_busy", busy, 1'b0);

    // single push latency
    src_req[0] = '{addr: 5'd5, data: 32'hDEADBEEF};
    src_valid  = 3'b001;
    check("single_ready", src_ready[0], 1'b1);
    step();
    src_valid = 3'b000;
    check("single_en_e1", data_write.write_en, 1'b0);
    check("single_busy_e1", busy, 1'b1);
    step();
    check("single_dw_e2", data_write, {1'b1, 5'd5, 32'hDEADBEEF});
    step();
    check("single_en_e3", data_write.write_en, 1'b0);
    check("single_busy_e3", busy, 1'b0);
    check("single_hold_addr", data_write.write_addr, 5'd5);

`ifdef REGFILE_WB_PENDING_QUERY_EN
    src_req[0] = mk(5'd7, 2'd0, 28'h77);
    src_valid  = 3'b001;
    step();
    src_valid = 3'b000;
    pend_query_addr = 5'd7;
    #1 check("pend_queued", pend_hit, 1'b1);
    pend_query_addr = 5'd0;
    #1 check("pend_zero", pend_hit, 1'b0);
    pend_query_addr = 5'd7;
    step();
    check("pend_outstage", pend_hit, 1'b1);
    step();
    check("pend_retired", pend_hit, 1'b0);
    pend_query_addr = 5'd0;
`endif

    // address 0 entry is consumed silently
    src_req[2] = '{addr: 5'd0, data: 32'h00001234};
    src_valid  = 3'b100;
    step();
    src_valid = 3'b000;
    check("a0_busy_q", busy, 1'b1);
    check("a0_en_q", data_write.write_en, 1'b0);
    step();
    check("a0_en_pop", data_write.write_en, 1'b0);
    check("a0_busy_pop", busy, 1'b0);
    check("a0_ready", src_ready[2], 1'b1);

    // three back-to-back pushes on one source: pop keeps pace so ready stays high
    for (int k = 0; k < 3; k++) begin
      src_req[1] = mk(5'(8 + k), 2'd1, 28'(16'h0300 + k));
      src_valid  = 3'b010;
      check("b2b_ready", src_ready[1], 1'b1);
      step();
    end
    src_valid = 3'b000;
    step(); step(); step();
    check("b2b_busy", busy, 1'b0);

    // two sources pushing every cycle fill their queues
    rst = 1'b0;
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    exp_r0 = 4'b0111;
    exp_r1 = 4'b1011;
    a0 = '{5'd11, 5'd12, 5'd13};
    a1 = '{5'd14, 5'd15, 5'd16};
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 8; c++) begin
      src_valid = 3'b000;
      if (n0 < 3) begin src_req[0] = mk(a0[n0], 2'd0, 28'(c)); src_valid[0] = 1'b1; end
      if (n1 < 3) begin src_req[1] = mk(a1[n1], 2'd1, 28'(c)); src_valid[1] = 1'b1; end
      if (c < 4) begin
        check("fill_ready0", src_ready[0], exp_r0[c]);
        check("fill_ready1", src_ready[1], exp_r1[c]);
      end
      step();
      if (xfer[0]) n0++;
      if (xfer[1]) n1++;
    end
    src_valid = 3'b000;
    check("fill_pushed", {n0[7:0], n1[7:0]}, {8'd3, 8'd3});
    for (int c = 0; c < 6; c++) step();
    check("fill_busy", busy, 1'b0);

    // address-0 grant still advances the round-robin pointer
    rst = 1'b0;
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    src_req[0] = mk(5'd0, 2'd0, 28'h55);
    src_valid  = 3'b001;
    step();
    src_valid = 3'b000;
    step();
    burst3(5'd17, 5'd18, 5'd19, 28'h0000400);
    step();
    src_valid = 3'b000;
    step(); check("rr_a18", data_write.write_addr, 5'd18);
    step(); check("rr_a19", data_write.write_addr, 5'd19);
    step(); check("rr_a17", data_write.write_addr, 5'd17);

    // flush with four writes pending
    burst3(5'd20, 5'd21, 5'd22, 28'h0000500);
    step();
    src_valid  = 3'b010;
    src_req[1] = mk(5'd23, 2'd1, 28'h0000501);
    step();
    check("fl_pre_addr", {data_write.write_en, data_write.write_addr}, {1'b1, 5'd21});
    src_valid = 3'b111;
    flush     = 1'b1;
    #1 check("fl_ready", src_ready, 3'b000);
    step();
    sb_clear();
    src_valid = 3'b000;
    flush     = 1'b0;
    check("fl_en", data_write.write_en, 1'b0);
    check("fl_busy", busy, 1'b0);
    check("fl_hold_addr", data_write.write_addr, 5'd21);
    for (int c = 0; c < 4; c++) step();
    check("fl_quiet", {busy, data_write.write_en}, 2'b00);

    // flush kept the pointer after src1, so src2 wins next; then async reset mid-cycle
    burst3(5'd24, 5'd25, 5'd26, 28'h0000600);
    step();
    src_valid = 3'b000;
    step();
    check("fl_ptr_kept", {data_write.write_en, data_write.write_addr}, {1'b1, 5'd26});
    #2 rst = 1'b0;
    #1;
    check("arst_dw", data_write, 64'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_ready", src_ready, 3'b000);
    sb_clear();
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    burst3(5'd27, 5'd28, 5'd29, 28'h0000700);
    step();
    src_valid = 3'b000;
    step(); check("arst_first", data_write.write_addr, 5'd27);
    step(); check("arst_second", data_write.write_addr, 5'd28);
    step(); check("arst_third", data_write.write_addr, 5'd29);
    step(); step();
    check("final_busy", busy, 1'b0);
    check("sb_drain", sb_count(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 3: number of writeback requesters (index 0 ALU, 1 MEM, 2 MULDIV).
REQ-002 Parameter FIFO_DEPTH, default 2: entries per requester queue, power of two, at least 2.
REQ-003 One clock, clk; reset rst is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  synchronous discard of all queued and staged writes.
REQ-007 src_valid  input  NUM_SRC  per-source write request valid.
REQ-008 src_ready  output  NUM_SRC  per-source queue not full and not flushing.
REQ-009 src_req  input  NUM_SRC x wb_req_t  per-source {addr[4:0], data[31:0]}.
REQ-010 data_write  output  data_write_t  registered write port {write_en, write_addr, write_data} to the register file.
REQ-011 busy  output  1  high while any queue or the output stage holds a write.

Function
REQ-012 A source transfer SHALL occur on an edge where src_valid[i] and src_ready[i] are both high; the entry is appended to queue i.
REQ-013 src_ready[i] SHALL be low when queue i is full or flush is high, and is combinational from state and flush only, never from src_valid.
REQ-014 Each edge, the arbiter SHALL pop at most one head entry from the non-empty queues, chosen round-robin starting from the index after the last granted source.
REQ-015 The popped entry SHALL load data_write on the same edge, giving write_en=1, write_addr=entry.addr and write_data=entry.data for exactly one cycle.
REQ-016 With no entry popped, write_en SHALL be 0, and write_addr/write_data SHALL hold their previous values.
REQ-017 Minimum latency SHALL be: accepted at edge k, write_en high from edge k+1, register file written at edge k+2.
REQ-018 Order SHALL be preserved within a source; cross-source order is round-robin only, and dispatch prevents same-register overlap.
REQ-019 An entry with addr 0 SHALL be popped and consumed normally but presented with write_en=0, and it still advances the round-robin pointer.
REQ-020 A simultaneous push and pop on a full queue SHALL be refused (src_ready low); a push and pop on a non-full queue SHALL both take effect.
REQ-021 Queue pointers SHALL wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.
REQ-022 flush high at an edge SHALL empty all queues, accept no pushes, pop nothing, force write_en to 0 at that edge and leave the round-robin pointer unchanged.
REQ-023 busy SHALL equal the OR of all queue non-empty flags and write_en.

Reset
REQ-024 While rst is low: all queues empty, round-robin pointer 0, data_write all-zero, busy 0, src_ready all 0.
REQ-025 Reset asserted mid-operation SHALL discard all pending writes immediately and asynchronously; the first grant after release goes to source 0.

Configuration
REQ-026 Macro REGFILE_WB_PENDING_QUERY_EN defined: ports pend_query_addr (input, 5) and pend_hit (output, 1) SHALL exist.
REQ-027 pend_hit SHALL be a combinational OR of address matches over all valid queue entries and the output stage when write_en is high; address 0 never hits.
REQ-028 Macro undefined: these ports and all compare logic SHALL be absent, with no other behaviour change.

Structure
REQ-029 wb_req_t and constant WB_NUM_SRC SHALL be added to package pipeline_types, alongside the existing data_write_t.
REQ-030 The per-source queue SHALL be a sub-module wb_fifo (parameter DEPTH), instantiated NUM_SRC times; arbitration and the output stage stay in regfile_wb_arbiter.

Verification
REQ-031 Single push: src0 {addr 5, data 0xDEADBEEF} at edge 1 -> write_en=1, addr 5, data 0xDEADBEEF after edge 2 only; busy falls after edge 3.
REQ-032 Contention: all three sources push at the same edge (addr 1/2/3) -> writes emerge in the order 1, 2, 3 on consecutive cycles, and the next simultaneous burst starts at source 0 again.
REQ-033 Full: 3 back-to-back pushes to src1 with no other traffic -> src_ready[1] low only when 2 entries are queued, no entry is lost, and data appears in push order.
REQ-034 Addr 0: src2 pushes {0, 0x1234} -> no write_en pulse, the entry is consumed, busy returns to 0.
REQ-035 Flush/reset: queue 4 entries, assert flush -> write_en 0 next cycle, busy 0, no later writes; repeat using rst pulled low mid-cycle -> outputs clear without waiting for a clock edge.
REQ-036 With REGFILE_WB_PENDING_QUERY_EN: queued addr 7, query 7 -> pend_hit=1; after the write retires -> 0; query 0 -> always 0.
